// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the fetch sequencer.
// Holds the state encoding, default vectors and branch-target arithmetic.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0380;

  function automatic logic [31:0] br_target(
    input logic [31:0] pc4,
    input logic [15:0] imm
  );
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_seq_npc.sv
// Next-PC select for redirects from execute and exceptions.
// Priority: exception, jr, j, taken branch.
module npc_target
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm,
  input  logic        j_valid,
  input  logic [25:0] j_index,
  input  logic        jr_valid,
  input  logic [31:0] jr_addr,
  input  logic        exc_valid,
  output logic        redir,
  output logic [31:0] target
);

  assign redir = exc_valid | jr_valid | j_valid
               | (br_valid & br_taken);

  always_comb begin
    target = br_target(br_pc4, br_imm);
    if (exc_valid)
      target = EXC_VECTOR;
    else if (jr_valid)
      target = jr_addr;
    else if (j_valid)
      target = {br_pc4[31:28], j_index, 2'b00};
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, runs req/ack to imem
// and hands words to decode over valid/ready.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm,
  input  logic        j_valid,
  input  logic [25:0] j_index,
  input  logic        jr_valid,
  input  logic [31:0] jr_addr,
  input  logic        exc_valid
);

  fetch_state_e state, nstate;
  logic [31:0]  pc, redir_pc, target;
  logic         redir_pend, redir;

  npc_target #(.EXC_VECTOR(EXC_VECTOR)) u_npc (
    .br_valid (br_valid),
    .br_taken (br_taken),
    .br_pc4   (br_pc4),
    .br_imm   (br_imm),
    .j_valid  (j_valid),
    .j_index  (j_index),
    .jr_valid (jr_valid),
    .jr_addr  (jr_addr),
    .exc_valid(exc_valid),
    .redir    (redir),
    .target   (target)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: nstate = S_REQ;
      S_REQ:
        if (imem_ack && !redir && !redir_pend)
          nstate = S_HOLD;
      S_HOLD:
        if (redir || inst_ready)
          nstate = S_REQ;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = (state == S_REQ);
    imem_addr  = pc;
    inst_valid = (state == S_HOLD);
    inst_pc4   = inst_pc + 32'd4;
  end

  // A redirect seen while a fetch is outstanding is parked until the ack
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      redir_pend <= 1'b0;
      redir_pc   <= 32'h0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
    end else begin
      case (state)
        S_REQ:
          if (imem_ack) begin
            redir_pend <= 1'b0;
            if (redir)
              pc <= target;
            else if (redir_pend)
              pc <= redir_pc;
            else begin
              inst    <= imem_rdata;
              inst_pc <= pc;
              pc      <= pc + 32'd4;
            end
          end else if (redir) begin
            redir_pc   <= target;
            redir_pend <= 1'b1;
          end
        S_HOLD:
          if (redir) pc <= target;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios with literal
// expectations, then randomized traffic against a transaction model.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst, inst_pc, inst_pc4;
  logic        br_valid, br_taken;
  logic [31:0] br_pc4;
  logic [15:0] br_imm;
  logic        j_valid;
  logic [25:0] j_index;
  logic        jr_valid;
  logic [31:0] jr_addr;
  logic        exc_valid;

  int nvec = 0;
  int nerr = 0;

  fetch_seq dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
    .br_valid(br_valid), .br_taken(br_taken),
    .br_pc4(br_pc4), .br_imm(br_imm),
    .j_valid(j_valid), .j_index(j_index),
    .jr_valid(jr_valid), .jr_addr(jr_addr),
    .exc_valid(exc_valid)
  );

  always #5 clk = ~clk;

  // Model: 0 = idle, 1 = fetch outstanding, 2 = word offered to decode
  int          m_mode;
  logic [31:0] m_pc, m_inst, m_ipc;
  logic [31:0] m_pend[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit m_redir();
    return exc_valid || jr_valid || j_valid || (br_valid && br_taken);
  endfunction

  function automatic logic [31:0] m_target();
    int signed off;
    if (exc_valid) return 32'h380;
    if (jr_valid) return jr_addr;
    if (j_valid) return (br_pc4 & 32'hF000_0000) | ({6'b0, j_index} * 4);
    off = int'($signed(br_imm)) * 4;
    return br_pc4 + 32'(off);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
      m_pend.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (imem_ack) begin
        if (m_redir()) m_pc = m_target();
        else if (m_pend.size() > 0) m_pc = m_pend[0];
        else begin
          m_inst = imem_rdata; m_ipc = m_pc; m_pc = m_pc + 4; m_mode = 2;
        end
        m_pend.delete();
      end else if (m_redir()) begin
        m_pend.delete();
        m_pend.push_back(m_target());
      end
    end else begin
      if (m_redir()) begin m_pc = m_target(); m_mode = 1; end
      else if (inst_ready) m_mode = 1;
    end
  endtask

  task automatic check_model();
    chk("imem_req", 32'(imem_req), 32'(m_mode == 1));
    if (m_mode == 1) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(m_mode == 2));
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("inst_pc4", inst_pc4, m_ipc + 4);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic clr_redir();
    br_valid = 0; br_taken = 0; j_valid = 0; jr_valid = 0; exc_valid = 0;
  endtask

  int  lat;
  bit  busy;

  initial begin
    rst = 1; imem_ack = 0; imem_rdata = 0; inst_ready = 0;
    clr_redir(); br_pc4 = 0; br_imm = 0; j_index = 0; jr_addr = 0;
    m_mode = 0; m_pc = 0; m_inst = 0; m_ipc = 0;
    @(negedge clk);
    step(); step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);

    // sequential fetch with same-cycle ack
    rst = 0; step();
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_req0", 32'(imem_req), 32'd1);
    inst_ready = 1;
    imem_ack = 1; imem_rdata = 32'h1111_0000; step();
    chk("t1_valid0", 32'(inst_valid), 32'd1);
    chk("t1_pc0", inst_pc, 32'h0);
    imem_ack = 0; step();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_novalid", 32'(inst_valid), 32'd0);
    imem_ack = 1; imem_rdata = 32'h2222_0004; step();
    chk("t1_pc4", inst_pc, 32'h4);
    imem_ack = 0; step();
    chk("t1_addr8", imem_addr, 32'h8);

    // decode stall
    imem_ack = 1; imem_rdata = 32'h3333_0008; step();
    imem_ack = 0; inst_ready = 0;
    repeat (5) begin
      step();
      chk("t2_pc", inst_pc, 32'h8);
      chk("t2_inst", inst, 32'h3333_0008);
      chk("t2_req", 32'(imem_req), 32'd0);
    end

    // branches from HOLD
    br_valid = 1; br_taken = 1; br_pc4 = 32'h100; br_imm = 16'hFFFE; step();
    chk("t3_back", imem_addr, 32'hF8);
    clr_redir(); imem_ack = 1; step();
    br_valid = 1; br_taken = 1; br_imm = 16'h0010; imem_ack = 0; step();
    chk("t3_fwd", imem_addr, 32'h140);
    clr_redir(); imem_ack = 1; step();
    imem_ack = 0; br_valid = 1; br_taken = 0; step();
    chk("t3_nt_valid", 32'(inst_valid), 32'd1);
    clr_redir(); inst_ready = 1; step();
    chk("t3_nt_addr", imem_addr, 32'h144);

    // jump while a fetch is outstanding
    j_valid = 1; j_index = 26'h40; br_pc4 = 32'h1000_0004; step();
    clr_redir(); step(); step();
    chk("t4_held", imem_addr, 32'h144);
    imem_ack = 1; step();
    chk("t4_drop", 32'(inst_valid), 32'd0);
    chk("t4_addr", imem_addr, 32'h1000_0100);

    // simultaneous redirects
    step();
    imem_ack = 0; exc_valid = 1; jr_valid = 1; jr_addr = 32'h400;
    br_valid = 1; br_taken = 1; step();
    chk("t5_exc", imem_addr, 32'h380);
    clr_redir();

    // reset mid-fetch, then ack in IDLE
    rst = 1; step();
    rst = 0; imem_ack = 1; step();
    chk("t6_valid", 32'(inst_valid), 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
    jr_valid = 1; jr_addr = 32'hFFFF_FFFC; step();
    clr_redir(); step();
    chk("t6_top", inst_pc, 32'hFFFF_FFFC);
    chk("t6_pc4", inst_pc4, 32'h0);
    imem_ack = 0; step();
    chk("t6_wrap", imem_addr, 32'h0);

    // randomized traffic
    busy = 0; lat = 0;
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom % 300) == 0;
      inst_ready = ($urandom % 10) < 7;
      exc_valid  = ($urandom % 40) == 0;
      jr_valid   = ($urandom % 20) == 0;
      j_valid    = ($urandom % 20) == 0;
      br_valid   = ($urandom % 6) == 0;
      br_taken   = $urandom % 2;
      br_pc4     = $urandom & 32'hFFFF_FFFC;
      br_imm     = 16'($urandom);
      j_index    = 26'($urandom);
      jr_addr    = $urandom & 32'hFFFF_FFFC;
      imem_rdata = $urandom;
      if (imem_req && !rst) begin
        if (!busy) begin busy = 1; lat = $urandom % 4; end
        imem_ack = (lat == 0);
        if (imem_ack) busy = 0;
        else lat--;
      end else begin
        busy = 0;
        imem_ack = ($urandom % 8) == 0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
